demod_integrator: RTL and testbench
===================================

DEMOD_INTEGRATOR -- requirements
Module: demod_integrator

Interface
REQ-001 SHALL provide parameter P_WIDTH, default 32: signed width of product input (mixer product from upstream multiplier).
REQ-002 SHALL provide parameter ACC_WIDTH, default 48: accumulator width; SHALL equal at least P_WIDTH+16.
REQ-003 SHALL provide parameter OUT_WIDTH, default 16: signed output width.
REQ-004 SHALL provide parameter OUT_SHIFT, default 0: extra arithmetic right shift applied after averaging.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  clock; all state changes on rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 en  input  1  enable; low holds block idle and discards partial window.
REQ-009 len_log2  input  5  window length exponent; window = 2^len_log2 valid samples; values >16 treated as 16.
REQ-010 p_in  input  P_WIDTH signed  product sample.
REQ-011 p_valid  input  1  p_in qualifier; one sample per cycle when high.
REQ-012 y  output  OUT_WIDTH signed  averaged, saturated result.
REQ-013 y_valid  output  1  one-cycle pulse marking new y.
REQ-014 sat  output  1  high with y_valid when the result was clipped; holds with y.
REQ-015 busy  output  1  high while a window is partially accumulated.

Function
REQ-016 SHALL implement states IDLE and ACCUM; IDLE->ACCUM when en=1; ACCUM->IDLE when en=0; no other transitions.
REQ-017 In IDLE: acc=0, count=0, busy=0, no p_in accepted.
REQ-018 In ACCUM, a cycle with p_valid=1 SHALL add sign-extended p_in to acc and increment count; p_valid=0 cycles SHALL change nothing.
REQ-019 Window length N SHALL be latched from len_log2 when count=0 and a sample is accepted (and on IDLE->ACCUM); changes mid-window take effect next window.
REQ-020 On the accepted sample with count=N-1: sum=acc+p_in; r = sum >>> (len_log2_latched+OUT_SHIFT) (arithmetic, floor toward -inf); y SHALL register sat(r) on that edge; y_valid SHALL be 1 the following cycle only; acc and count SHALL clear on the same edge (no sample lost; next sample starts new window).
REQ-021 Latency: y_valid asserted exactly 1 cycle after the clock edge capturing the window's last sample.
REQ-022 Saturation: r > 2^(OUT_WIDTH-1)-1 -> y=2^(OUT_WIDTH-1)-1, sat=1; r < -2^(OUT_WIDTH-1) -> y=-2^(OUT_WIDTH-1), sat=1; else y=r[OUT_WIDTH-1:0], sat=0.
REQ-023 acc SHALL never overflow for any input sequence (guaranteed by REQ-002 and N<=2^16).
REQ-024 len_log2=0: every accepted sample SHALL produce y_valid next cycle (pass-through with shift/saturation).
REQ-025 en falling mid-window SHALL discard acc and count, emit no y_valid; y and sat SHALL hold last values.
REQ-026 busy SHALL be 1 when state=ACCUM and count!=0.
REQ-027 y and sat SHALL hold between y_valid pulses.

Reset
REQ-028 rst=1 SHALL force, on the next edge: state=IDLE, acc=0, count=0, latched N=1, y=0, y_valid=0, sat=0, busy=0.
REQ-029 rst SHALL take priority over en, p_valid and window completion in the same cycle; a window completing in a reset cycle SHALL NOT produce y_valid.

Verification
REQ-030 en=1, len_log2=2, p_in=100 on 4 consecutive valid cycles -> y=100, sat=0, single y_valid pulse one cycle after 4th sample.
REQ-031 len_log2=2, p_in=-3,-3,-3,-2 -> sum -11, y=-3 (floor), y_valid once.
REQ-032 len_log2=0, p_in=1048576 -> y=32767, sat=1; then p_in=-1048576 -> y=-32768, sat=1; then p_in=5 -> y=5, sat=0.
REQ-033 len_log2=3, 8 samples of 7 interleaved with random p_valid=0 gaps -> y=7, y_valid only after 8th valid sample; len_log2 changed to 1 mid-window does not affect this window.
REQ-034 en dropped after 3 of 4 samples, re-raised, 4 samples of 20 -> only one y_valid, y=20; y held old value during gap.
REQ-035 rst asserted on the cycle of the 4th sample -> no y_valid, all outputs 0 next cycle; subsequent window of 4x(-8) -> y=-8.

Source files
------------

// File: rtl/demod_integrator_if.sv
// Sample/result bundle between the mixer product source and the demod integrator.
// The source drives the product stream and window controls; the integrator returns averaged results.
interface demod_integrator_if #(
  parameter int P_WIDTH   = 32,
  parameter int OUT_WIDTH = 16
);
  logic                        en;
  logic [4:0]                  len_log2;
  logic signed [P_WIDTH-1:0]   p_in;
  logic                        p_valid;
  logic signed [OUT_WIDTH-1:0] y;
  logic                        y_valid;
  logic                        sat;
  logic                        busy;

  modport master (output en, len_log2, p_in, p_valid, input y, y_valid, sat, busy);
  modport slave  (input en, len_log2, p_in, p_valid, output y, y_valid, sat, busy);
endinterface

// File: rtl/demod_integrator.sv
// Integrate-and-dump averager: sums 2^len_log2 valid products, shifts down by the
// window exponent plus OUT_SHIFT, and saturates into a signed OUT_WIDTH result.
module demod_integrator #(
  parameter int P_WIDTH   = 32,
  parameter int ACC_WIDTH = 48,
  parameter int OUT_WIDTH = 16,
  parameter int OUT_SHIFT = 0
) (
  input  logic             clk,
  input  logic             rst,
  demod_integrator_if.slave bus
);
  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic signed [ACC_WIDTH-1:0] Y_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] Y_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  state_t                      state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [15:0]                 cnt_q, cnt_d;
  logic [4:0]                  len_q, len_d;
  logic signed [OUT_WIDTH-1:0] y_q, y_d;
  logic                        sat_q, sat_d;
  logic                        y_valid_q, y_valid_d;

  logic [4:0]                  len_clamp, len_eff;
  logic signed [ACC_WIDTH-1:0] sum, r;
  logic [7:0]                  shamt;
  logic                        last;
  logic signed [OUT_WIDTH-1:0] y_sat;
  logic                        sat_flag;

  always_comb begin
    len_clamp = (bus.len_log2 > 5'd16) ? 5'd16 : bus.len_log2;
    // The first sample of a window already uses the freshly latched length,
    // which is what lets len_log2=0 complete on every sample.
    len_eff   = (cnt_q == 16'd0) ? len_clamp : len_q;
    sum       = acc_q + ACC_WIDTH'(bus.p_in);
    shamt     = 8'(len_eff) + 8'(OUT_SHIFT);
    r         = sum >>> shamt;
    last      = ({1'b0, cnt_q} == ((17'd1 << len_eff) - 17'd1));
    y_sat     = r[OUT_WIDTH-1:0];
    sat_flag  = 1'b0;
    if (r > Y_MAX) begin
      y_sat    = Y_MAX[OUT_WIDTH-1:0];
      sat_flag = 1'b1;
    end else if (r < Y_MIN) begin
      y_sat    = Y_MIN[OUT_WIDTH-1:0];
      sat_flag = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    y_d       = y_q;
    sat_d     = sat_q;
    y_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        acc_d = '0;
        cnt_d = '0;
        if (bus.en) begin
          state_d = ACCUM;
          len_d   = len_clamp;
        end
      end
      ACCUM: begin
        if (!bus.en) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (bus.p_valid) begin
          if (cnt_q == 16'd0) len_d = len_clamp;
          if (last) begin
            acc_d     = '0;
            cnt_d     = '0;
            y_d       = y_sat;
            sat_d     = sat_flag;
            y_valid_d = 1'b1;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      y_q       <= '0;
      sat_q     <= 1'b0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      y_q       <= y_d;
      sat_q     <= sat_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign bus.y       = y_q;
  assign bus.sat     = sat_q;
  assign bus.y_valid = y_valid_q;
  assign bus.busy    = (state_q == ACCUM) && (cnt_q != 16'd0);
endmodule

// File: tb/tb_demod_integrator.sv
// Randomized and directed checks of demod_integrator against a window-level
// reference model that collects accepted samples in a queue and averages them.
module tb_demod_integrator;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  demod_integrator_if #(.P_WIDTH(32), .OUT_WIDTH(16)) bus ();

  demod_integrator #(.P_WIDTH(32), .ACC_WIDTH(48), .OUT_WIDTH(16), .OUT_SHIFT(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model state
  bit     m_active = 0;
  int     m_len    = 0;
  longint m_q[$];
  longint m_y = 0;
  bit     m_sat = 0;
  bit     m_yv  = 0;

  task automatic model_step(input bit r, input bit e, input int len, input longint p, input bit pv);
    longint s, rr;
    m_yv = 0;
    if (r) begin
      m_active = 0; m_q.delete(); m_y = 0; m_sat = 0; m_len = 0;
    end else if (!m_active) begin
      if (e) begin m_active = 1; m_len = (len > 16) ? 16 : len; end
    end else if (!e) begin
      m_active = 0; m_q.delete();
    end else if (pv) begin
      if (m_q.size() == 0) m_len = (len > 16) ? 16 : len;
      m_q.push_back(p);
      if (m_q.size() == (1 << m_len)) begin
        s = 0;
        foreach (m_q[i]) s += m_q[i];
        rr = s >>> m_len;
        if (rr > 32767)       begin m_y = 32767;  m_sat = 1; end
        else if (rr < -32768) begin m_y = -32768; m_sat = 1; end
        else                  begin m_y = rr;     m_sat = 0; end
        m_yv = 1;
        m_q.delete();
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare.
  task automatic cyc(input bit r, input bit e, input int len, input longint p, input bit pv);
    rst          = r;
    bus.en       = e;
    bus.len_log2 = 5'(len);
    bus.p_in     = 32'(p);
    bus.p_valid  = pv;
    @(posedge clk);
    model_step(r, e, len, p, pv);
    @(negedge clk);
    chk("y_valid", longint'(bus.y_valid), longint'(m_yv));
    chk("y", longint'(bus.y), m_y);
    chk("sat", longint'(bus.sat), longint'(m_sat));
    chk("busy", longint'(bus.busy), longint'(m_active && m_q.size() != 0));
  endtask

  int yv_cnt;

  initial begin
    @(negedge clk);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 2, 5, 1);
    chk("rst_y", longint'(bus.y), 0);
    chk("rst_busy", longint'(bus.busy), 0);

    // Four equal samples average to themselves
    cyc(0, 1, 2, 0, 0);
    repeat (4) cyc(0, 1, 2, 100, 1);
    chk("avg100_y", longint'(bus.y), 100);
    chk("avg100_vld", longint'(bus.y_valid), 1);
    cyc(0, 1, 2, 0, 0);
    chk("avg100_pulse", longint'(bus.y_valid), 0);

    // Floor rounding of a negative sum
    cyc(0, 1, 2, -3, 1); cyc(0, 1, 2, -3, 1); cyc(0, 1, 2, -3, 1); cyc(0, 1, 2, -2, 1);
    chk("floor_y", longint'(bus.y), -3);

    // Pass-through with saturation
    cyc(0, 1, 0, 1048576, 1);
    chk("satp_y", longint'(bus.y), 32767);
    chk("satp_sat", longint'(bus.sat), 1);
    cyc(0, 1, 0, -1048576, 1);
    chk("satn_y", longint'(bus.y), -32768);
    chk("satn_sat", longint'(bus.sat), 1);
    cyc(0, 1, 0, 5, 1);
    chk("pass_y", longint'(bus.y), 5);
    chk("pass_sat", longint'(bus.sat), 0);

    // Gapped window with a mid-window length change
    yv_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      while ($urandom_range(0, 2) == 0) cyc(0, 1, (i >= 3) ? 1 : 3, 0, 0);
      cyc(0, 1, (i >= 3) ? 1 : 3, 7, 1);
      if (bus.y_valid) yv_cnt++;
    end
    chk("gap_y", longint'(bus.y), 7);
    chk("gap_pulses", yv_cnt, 1);

    // Enable dropped mid-window discards the partial sum
    cyc(0, 1, 2, 0, 0);
    repeat (3) cyc(0, 1, 2, 55, 1);
    cyc(0, 0, 2, 0, 0);
    chk("drop_hold_y", longint'(bus.y), 7);
    chk("drop_busy", longint'(bus.busy), 0);
    cyc(0, 1, 2, 0, 0);
    repeat (4) cyc(0, 1, 2, 20, 1);
    chk("drop_y", longint'(bus.y), 20);

    // Reset on the completing sample suppresses the result
    repeat (3) cyc(0, 1, 2, 9, 1);
    cyc(1, 1, 2, 9, 1);
    chk("rstwin_vld", longint'(bus.y_valid), 0);
    chk("rstwin_y", longint'(bus.y), 0);
    cyc(0, 1, 2, 0, 0);
    repeat (4) cyc(0, 1, 2, -8, 1);
    chk("rstwin_next_y", longint'(bus.y), -8);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      int     len;
      longint p;
      len = ($urandom_range(0, 99) == 0) ? int'($urandom_range(17, 20)) : int'($urandom_range(0, 3));
      p   = longint'($signed($urandom()));
      if ($urandom_range(0, 1) == 0) p = p >>> 12;
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 29) != 0, len, p, $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
